// File: rtl/dm_port_arbiter_if.sv
// Data-memory port bundle: M-stage side, DMA side and the memory itself.
// slave is the arbiter's view, master is the surrounding system's view.
interface dm_port_arbiter_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wd;
    logic [31:0] cpu_rd;
    logic        cpu_stall;

    logic        dma_req;
    logic        dma_we;
    logic [31:0] dma_addr;
    logic [4:0]  dma_len;
    logic [31:0] dma_wd;
    logic        dma_gnt;
    logic        dma_rvalid;
    logic [31:0] dma_rd;
    logic        dma_done;

    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wd,
        output cpu_rd, cpu_stall,
        input  dma_req, dma_we, dma_addr, dma_len, dma_wd,
        output dma_gnt, dma_rvalid, dma_rd, dma_done,
        output mem_we, mem_addr, mem_wd,
        input  mem_rd
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wd,
        input  cpu_rd, cpu_stall,
        output dma_req, dma_we, dma_addr, dma_len, dma_wd,
        input  dma_gnt, dma_rvalid, dma_rd, dma_done,
        input  mem_we, mem_addr, mem_wd,
        output mem_rd
    );
endinterface

// File: rtl/dm_port_arbiter.sv
// Shares the single data-memory port between the M stage and a DMA
// engine: CPU first, DMA in bursts when idle or after starvation.
module dm_port_arbiter #(
    parameter int STARVE_LIMIT = 8,
    parameter int MAX_BURST    = 16
) (
    input  logic             clk,
    input  logic             reset,
    dm_port_arbiter_if.slave bus
);
    localparam logic [0:0] S_CPU = 1'b0;
    localparam logic [0:0] S_DMA = 1'b1;
    localparam logic [7:0] STARVE_LAST = 8'(STARVE_LIMIT - 1);
    localparam logic [4:0] BURST_MAX   = 5'(MAX_BURST);

    logic [0:0]  state_q, state_d;
    logic [7:0]  starve_cnt_q, starve_cnt_d;
    logic [4:0]  beat_cnt_q, beat_cnt_d;
    logic [4:0]  len_q, len_d;
    logic [31:0] base_q, base_d;
    logic        done_q, done_d;

    logic [4:0]  clamp_len;
    logic        in_dma;
    logic        last_beat;
    logic        grant;
    logic        unused_addr_bits;

    assign in_dma    = (state_q == S_DMA);
    assign last_beat = (beat_cnt_q == len_q - 5'd1);
    assign grant     = bus.dma_req &
                       (!bus.cpu_req || starve_cnt_q == STARVE_LAST);

    assign unused_addr_bits = ^{bus.cpu_addr[1:0], bus.dma_addr[1:0]};

    always_comb begin
        if (bus.dma_len == 5'd0)
            clamp_len = 5'd1;
        else if (bus.dma_len > BURST_MAX)
            clamp_len = BURST_MAX;
        else
            clamp_len = bus.dma_len;
    end

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        beat_cnt_d   = beat_cnt_q;
        len_d        = len_q;
        base_d       = base_q;
        done_d       = 1'b0;
        unique case (state_q)
            S_CPU: begin
                if (!bus.dma_req)
                    starve_cnt_d = '0;
                else if (bus.cpu_req && starve_cnt_q != 8'hFF)
                    starve_cnt_d = starve_cnt_q + 8'd1;
                if (grant) begin
                    state_d      = S_DMA;
                    base_d       = {bus.dma_addr[31:2], 2'b00};
                    len_d        = clamp_len;
                    beat_cnt_d   = '0;
                    starve_cnt_d = '0;
                end
            end
            S_DMA: begin
                // a dropped request aborts the burst without a done pulse
                if (!bus.dma_req) begin
                    state_d = S_CPU;
                end else begin
                    beat_cnt_d = beat_cnt_q + 5'd1;
                    if (last_beat) begin
                        state_d = S_CPU;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = S_CPU;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_CPU;
            starve_cnt_q <= '0;
            beat_cnt_q   <= '0;
            len_q        <= '0;
            base_q       <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            beat_cnt_q   <= beat_cnt_d;
            len_q        <= len_d;
            base_q       <= base_d;
            done_q       <= done_d;
        end
    end

    always_comb begin
        bus.mem_addr   = {bus.cpu_addr[31:2], 2'b00};
        bus.mem_wd     = bus.cpu_wd;
        bus.mem_we     = bus.cpu_req & bus.cpu_we;
        bus.cpu_stall  = 1'b0;
        bus.dma_gnt    = 1'b0;
        bus.dma_rvalid = 1'b0;
        if (in_dma) begin
            bus.mem_addr   = base_q + {25'd0, beat_cnt_q, 2'b00};
            bus.mem_wd     = bus.dma_wd;
            bus.mem_we     = bus.dma_req & bus.dma_we;
            bus.cpu_stall  = bus.cpu_req;
            bus.dma_gnt    = 1'b1;
            bus.dma_rvalid = bus.dma_req & !bus.dma_we;
        end
    end

    assign bus.cpu_rd   = bus.mem_rd;
    assign bus.dma_rd   = bus.mem_rd;
    assign bus.dma_done = done_q;
endmodule

// File: tb/tb_dm_port_arbiter.sv
// Scoreboard bench for dm_port_arbiter: expected port views are queued
// as stimulus is launched and popped each cycle against the DUT.
module tb_dm_port_arbiter;
    typedef struct packed {
        logic        gnt;
        logic        stall;
        logic        we;
        logic        rv;
        logic        done;
        logic [31:0] addr;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] mem [256];
    exp_t        sb[$];
    int          n_run  = 0;
    int          n_fail = 0;

    dm_port_arbiter_if bus();

    dm_port_arbiter #(.STARVE_LIMIT(8), .MAX_BURST(16)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (bus.mem_we) mem[bus.mem_addr[9:2]] <= bus.mem_wd;

    assign bus.mem_rd = mem[bus.mem_addr[9:2]];

    function automatic exp_t mk(logic g, logic s, logic w, logic r,
                                logic d, logic [31:0] a);
        return {g, s, w, r, d, a};
    endfunction

    function automatic exp_t obs();
        return {bus.dma_gnt, bus.cpu_stall, bus.mem_we,
                bus.dma_rvalid, bus.dma_done, bus.mem_addr};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.cpu_req  = 1'b0;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = '0;
        bus.cpu_wd   = '0;
        bus.dma_req  = 1'b0;
        bus.dma_we   = 1'b0;
        bus.dma_addr = '0;
        bus.dma_len  = '0;
        bus.dma_wd   = '0;
    endtask

    task automatic test_reset();
        exp_t o, e;
        reset = 1'b1;
        idle();
        bus.cpu_addr = 32'h47;
        tick();
        tick();
        reset = 1'b0;
        sb.push_back(mk(0, 0, 0, 0, 0, 32'h44));
        #2;
        o = obs();
        e = sb.pop_front();
        n_run++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL reset got=%h exp=%h", o, e);
        end
        n_run++;
        if (dut.starve_cnt_q !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_starve got=%0d exp=0", dut.starve_cnt_q);
        end
    endtask

    task automatic test_cpu_write();
        exp_t o, e;
        sb.push_back(mk(0, 0, 1, 0, 0, 32'h10));
        sb.push_back(mk(0, 0, 0, 0, 0, 32'h10));
        for (int c = 0; c < 2; c++) begin
            tick();
            idle();
            bus.cpu_req  = 1'b1;
            bus.cpu_we   = (c == 0);
            bus.cpu_addr = (c == 0) ? 32'h13 : 32'h10;
            bus.cpu_wd   = 32'h1234_5678;
            #2;
            o = obs();
            e = sb.pop_front();
            n_run++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL cpu_write c%0d got=%h exp=%h", c, o, e);
            end
        end
        n_run++;
        if (bus.cpu_rd !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL cpu_read got=%h exp=12345678", bus.cpu_rd);
        end
    endtask

    task automatic test_dma_read();
        exp_t o, e;
        for (int i = 0; i < 4; i++)
            sb.push_back(mk(0, 0, 1, 0, 0, 32'h100 + 32'(4 * i)));
        sb.push_back(mk(0, 0, 0, 0, 0, 32'h0));
        for (int i = 0; i < 4; i++)
            sb.push_back(mk(1, 0, 0, 1, 0, 32'h100 + 32'(4 * i)));
        sb.push_back(mk(0, 0, 0, 0, 1, 32'h0));
        sb.push_back(mk(0, 0, 0, 0, 0, 32'h0));
        for (int c = 0; c < 11; c++) begin
            tick();
            idle();
            if (c < 4) begin
                bus.cpu_req  = 1'b1;
                bus.cpu_we   = 1'b1;
                bus.cpu_addr = 32'h100 + 32'(4 * c);
                bus.cpu_wd   = 32'hA000_0000 + 32'(c);
            end else if (c <= 8) begin
                bus.dma_req  = 1'b1;
                bus.dma_addr = (c == 4) ? 32'h102 : 32'hDEAD_0000;
                bus.dma_len  = (c == 4) ? 5'd4 : 5'd31;
            end
            #2;
            o = obs();
            e = sb.pop_front();
            n_run++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL dma_read c%0d got=%h exp=%h", c, o, e);
            end
            if (c >= 5 && c <= 8) begin
                n_run++;
                if (bus.dma_rd !== 32'hA000_0000 + 32'(c - 5)) begin
                    n_fail++;
                    $display("FAIL dma_rd c%0d got=%h exp=%h", c,
                             bus.dma_rd, 32'hA000_0000 + 32'(c - 5));
                end
            end
        end
    endtask

    task automatic test_starvation();
        exp_t o, e;
        for (int c = 0; c < 8; c++)
            sb.push_back(mk(0, 0, 0, 0, 0, 32'h200));
        sb.push_back(mk(1, 1, 0, 1, 0, 32'h300));
        sb.push_back(mk(1, 1, 0, 1, 0, 32'h304));
        sb.push_back(mk(0, 0, 0, 0, 1, 32'h200));
        sb.push_back(mk(0, 0, 0, 0, 0, 32'h200));
        for (int c = 0; c < 12; c++) begin
            tick();
            idle();
            bus.cpu_req  = 1'b1;
            bus.cpu_addr = 32'h200;
            bus.dma_req  = (c < 10);
            bus.dma_addr = 32'h300;
            bus.dma_len  = 5'd2;
            #2;
            o = obs();
            e = sb.pop_front();
            n_run++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL starve c%0d got=%h exp=%h", c, o, e);
            end
        end
    endtask

    task automatic test_abort();
        exp_t o, e;
        sb.push_back(mk(0, 0, 1, 0, 0, 32'h88));
        sb.push_back(mk(0, 0, 0, 0, 0, 32'h0));
        sb.push_back(mk(1, 0, 1, 0, 0, 32'h80));
        sb.push_back(mk(1, 0, 1, 0, 0, 32'h84));
        sb.push_back(mk(1, 0, 0, 0, 0, 32'h88));
        sb.push_back(mk(0, 0, 1, 0, 0, 32'h3C0));
        sb.push_back(mk(0, 0, 0, 0, 0, 32'h3C0));
        for (int c = 0; c < 7; c++) begin
            tick();
            idle();
            unique case (c)
                0: begin
                    bus.cpu_req  = 1'b1;
                    bus.cpu_we   = 1'b1;
                    bus.cpu_addr = 32'h88;
                    bus.cpu_wd   = 32'h5A5A_5A5A;
                end
                1, 2, 3: begin
                    bus.dma_req  = 1'b1;
                    bus.dma_we   = 1'b1;
                    bus.dma_addr = 32'h80;
                    bus.dma_len  = 5'd8;
                    bus.dma_wd   = 32'hB0 + 32'(c - 2);
                end
                5: begin
                    bus.cpu_req  = 1'b1;
                    bus.cpu_we   = 1'b1;
                    bus.cpu_addr = 32'h3C0;
                    bus.cpu_wd   = 32'hC0DE_0001;
                end
                6: begin
                    bus.cpu_req  = 1'b1;
                    bus.cpu_addr = 32'h3C0;
                end
                default: ;
            endcase
            #2;
            o = obs();
            e = sb.pop_front();
            n_run++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL abort c%0d got=%h exp=%h", c, o, e);
            end
        end
        n_run++;
        if (bus.cpu_rd !== 32'hC0DE_0001) begin
            n_fail++;
            $display("FAIL abort_cpu_rd got=%h exp=c0de0001", bus.cpu_rd);
        end
        n_run++;
        if ({mem[8'h20], mem[8'h21], mem[8'h22]} !==
            {32'hB0, 32'hB1, 32'h5A5A_5A5A}) begin
            n_fail++;
            $display("FAIL abort_mem got=%h %h %h exp=b0 b1 5a5a5a5a",
                     mem[8'h20], mem[8'h21], mem[8'h22]);
        end
    endtask

    task automatic test_len_bounds();
        exp_t        o, e;
        logic [31:0] bases [3] = '{32'h200, 32'h240, 32'hFFFF_FFF8};
        logic [4:0]  lens  [3] = '{5'd0, 5'd20, 5'd4};
        int          beats [3] = '{1, 16, 4};
        for (int k = 0; k < 3; k++) begin
            sb.push_back(mk(0, 0, 0, 0, 0, 32'h0));
            for (int i = 0; i < beats[k]; i++)
                sb.push_back(mk(1, 0, 0, 1, 0, bases[k] + 32'(4 * i)));
            sb.push_back(mk(0, 0, 0, 0, 1, 32'h0));
            for (int c = 0; c <= beats[k] + 1; c++) begin
                tick();
                idle();
                bus.dma_req  = (c <= beats[k]);
                bus.dma_addr = (c == 0) ? bases[k] : 32'h0BAD_0000;
                bus.dma_len  = (c == 0) ? lens[k] : 5'd31;
                #2;
                o = obs();
                e = sb.pop_front();
                n_run++;
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL len_bounds k%0d c%0d got=%h exp=%h",
                             k, c, o, e);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t o, e;
        sb.push_back(mk(0, 0, 0, 0, 0, 32'h0));
        sb.push_back(mk(1, 0, 0, 1, 0, 32'h600));
        sb.push_back(mk(0, 0, 0, 0, 1, 32'h0));
        sb.push_back(mk(1, 0, 0, 1, 0, 32'h700));
        sb.push_back(mk(0, 0, 0, 0, 1, 32'h0));
        for (int c = 0; c < 5; c++) begin
            tick();
            idle();
            bus.dma_req  = (c < 4);
            bus.dma_addr = (c == 0) ? 32'h600 : 32'h700;
            bus.dma_len  = 5'd1;
            #2;
            o = obs();
            e = sb.pop_front();
            n_run++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL back_to_back c%0d got=%h exp=%h", c, o, e);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        exp_t o, e;
        sb.push_back(mk(0, 0, 0, 0, 0, 32'h0));
        for (int i = 0; i < 3; i++)
            sb.push_back(mk(1, 0, 1, 0, 0, 32'hC0 + 32'(4 * i)));
        sb.push_back(mk(0, 0, 1, 0, 0, 32'h2E4));
        sb.push_back(mk(0, 0, 0, 0, 0, 32'h0));
        for (int c = 0; c < 6; c++) begin
            tick();
            idle();
            reset = (c == 3);
            if (c <= 3) begin
                bus.dma_req  = 1'b1;
                bus.dma_we   = 1'b1;
                bus.dma_addr = 32'hC0;
                bus.dma_len  = 5'd8;
                bus.dma_wd   = 32'hE0 + 32'(c);
            end else if (c == 4) begin
                bus.cpu_req  = 1'b1;
                bus.cpu_we   = 1'b1;
                bus.cpu_addr = 32'h2E7;
                bus.dma_req  = 1'b1;
            end
            #2;
            o = obs();
            e = sb.pop_front();
            n_run++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL reset_mid c%0d got=%h exp=%h", c, o, e);
            end
            if (c == 4) begin
                n_run++;
                if (dut.starve_cnt_q !== 8'd0) begin
                    n_fail++;
                    $display("FAIL reset_mid_starve got=%0d exp=0",
                             dut.starve_cnt_q);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        idle();
        test_reset();
        test_cpu_write();
        test_dma_read();
        test_starvation();
        test_abort();
        test_len_bounds();
        test_back_to_back();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/dm_port_arbiter.md
Name: dm_port_arbiter

Overview:
- Owns the single data-memory port (combinational read, write on `clk` edge) and shares it between two requesters: the pipeline M stage (CPU side) and a DMA/loader engine.
- The CPU side has priority. DMA is served in word bursts, either when the CPU port is idle or when DMA starvation forces a handover.
- The block generates the stall request for the pipeline and the burst addressing for DMA.

Parameters:
- STARVE_LIMIT, 8, number of consecutive contended cycles (CPU and DMA both requesting) after which DMA is forced in. Range 1..255.
- MAX_BURST, 16, maximum beats per DMA burst. Longer requests are clamped. Range 1..31.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cpu_req  in  1  M-stage memory access this cycle
- cpu_we  in  1  M-stage write enable
- cpu_addr  in  32  M-stage byte address
- cpu_wd  in  32  M-stage write data (already forwarded)
- cpu_rd  out  32  read data to the M stage
- cpu_stall  out  1  freeze request to the hazard/stall logic
- dma_req  in  1  DMA wants the port / beat valid
- dma_we  in  1  DMA burst is a write
- dma_addr  in  32  burst base byte address, sampled at grant
- dma_len  in  5  beats requested, sampled at grant
- dma_wd  in  32  write data for the current beat
- dma_gnt  out  1  DMA owns the port this cycle
- dma_rvalid  out  1  dma_rd is valid this cycle
- dma_rd  out  32  read data for the current beat
- dma_done  out  1  one-cycle pulse after the last beat of a completed burst
- mem_we  out  1  to data memory
- mem_addr  out  32  byte address to data memory, bits [1:0] forced to 0
- mem_wd  out  32  to data memory
- mem_rd  in  32  from data memory

Behaviour:
- **States:** S_CPU (reset state) and S_DMA.
- **Registers:** state, starve_cnt[7:0], beat_cnt[4:0], len_q[4:0], base_q[31:0], dma_done.
  - All registers clear on reset.
  - Reset mid-burst immediately returns to S_CPU; no dma_done pulse is produced.
- **S_CPU outputs:**
  - mem_addr = {cpu_addr[31:2], 2'b00}, mem_wd = cpu_wd, mem_we = cpu_req & cpu_we.
  - cpu_stall = 0, dma_gnt = 0, dma_rvalid = 0.
  - A CPU access completes in the same cycle; there is no added latency.
- **S_CPU counters:**
  - starve_cnt increments (saturating) each cycle in which dma_req & cpu_req.
  - starve_cnt clears on any cycle with dma_req = 0.
- **S_CPU → S_DMA:** taken when dma_req & (!cpu_req | starve_cnt == STARVE_LIMIT-1). On that edge:
  - base_q ← {dma_addr[31:2], 2'b00}
  - len_q ← (dma_len == 0) ? 1 : min(dma_len, MAX_BURST)
  - beat_cnt ← 0, starve_cnt ← 0
  - The port is granted on the next cycle, so DMA arbitration latency is 1 cycle.
- **S_DMA outputs:**
  - dma_gnt = 1.
  - mem_addr = base_q + {beat_cnt, 2'b00}, computed modulo 2^32 (wraps through 0xFFFFFFFC → 0x0).
  - mem_wd = dma_wd, mem_we = dma_req & dma_we.
  - dma_rvalid = dma_req & !dma_we.
  - cpu_stall = cpu_req, and the CPU access is not performed.
- **S_DMA beats:**
  - A beat completes on each cycle with dma_req = 1; beat_cnt then increments.
  - dma_we is sampled per beat. The engine holds it constant across a burst.
- **S_DMA transitions:**
  - **Last beat:** when a beat completes with beat_cnt == len_q-1, go to S_CPU and set dma_done = 1 for exactly the following cycle.
  - **Abort:** when dma_req = 0 in S_DMA, go to S_CPU on the next edge. No access occurs that cycle and dma_done stays 0.
- **Back-to-back bursts:**
  - After returning to S_CPU, a new burst is re-arbitrated under the normal S_CPU rules.
  - A waiting DMA therefore gets at least one S_CPU cycle between bursts.
- **Read data:** cpu_rd = dma_rd = mem_rd (direct pass-through).

Test Plan:
1. **CPU write, no DMA.** Reset, then cpu_req=1, cpu_we=1, cpu_addr=0x13, cpu_wd=0x12345678, dma_req=0 → same cycle mem_we=1, mem_addr=0x10, cpu_stall=0. Then a read of 0x10 returns 0x12345678 on cpu_rd.
2. **Idle-port DMA read burst.** cpu_req=0, dma_req=1, dma_we=0, dma_addr=0x100, dma_len=4 → dma_gnt rises 1 cycle later. mem_addr is 0x100, 0x104, 0x108, 0x10C on 4 consecutive cycles with dma_rvalid=1. dma_done=1 for one cycle afterwards, then state is S_CPU.
3. **Starvation handover.** cpu_req held 1, dma_req held 1, STARVE_LIMIT=8, dma_len=2 → CPU is served for exactly 8 cycles. Then cpu_stall=1 for 2 cycles while DMA is granted, then cpu_stall=0.
4. **Abort mid-burst.** dma_len=8, dma_we=1; dma_req drops after 2 beats → exactly 2 writes occur, dma_gnt=0 next cycle, no dma_done pulse, subsequent CPU write performed normally.
5. **Length boundaries and address wrap.**
   - dma_len=0 → 1 beat.
   - dma_len=20 → 16 beats.
   - dma_addr=0xFFFFFFF8, len=4 → addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
6. **Reset mid-burst.** Assert reset during beat 3 of an 8-beat burst → next cycle dma_gnt=0, cpu_stall=0, dma_done=0, mem_we follows the CPU side only, starve_cnt=0.
